// File: rtl/pix_capture_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : pix_capture_writer_if
// Description : Port A bundle of the pixel capture BRAM. The writer drives it
//               through the master modport; the BRAM side observes it through
//               the slave modport.
// Revision    : 1.0 - initial release
// ============================================================================
interface pix_capture_writer_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              bram_we;
  logic              bram_en_a;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wr_data;

  modport master (output bram_we, bram_en_a, bram_addr, bram_wr_data);
  modport slave  (input  bram_we, bram_en_a, bram_addr, bram_wr_data);
endinterface
`default_nettype wire

// File: rtl/pix_capture_writer.sv
`default_nettype none
// ============================================================================
// Module      : pix_capture_writer
// Description : Picks one channel out of a time-multiplexed pixel stream and
//               writes a run of its samples into the capture BRAM (port A)
//               after an arm + trigger sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module pix_capture_writer #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int CH_W   = 8,
  parameter int NUM_CH = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 din_valid,
  input  logic                 din_sof,
  input  logic [DATA_W-1:0]    din_data,
  input  logic [CH_W-1:0]      ch_sel,
  input  logic [ADDR_W:0]      num_samples,
  input  logic                 arm,
  input  logic                 abort,
  input  logic                 trig,
  pix_capture_writer_if.master port_a,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W:0]      wr_count
);

  localparam logic [1:0]        c_st_idle    = 2'd0;
  localparam logic [1:0]        c_st_armed   = 2'd1;
  localparam logic [1:0]        c_st_capture = 2'd2;
  localparam logic [1:0]        c_st_done    = 2'd3;
  localparam logic [ADDR_W:0]   c_depth      = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [CH_W-1:0]   c_last_ch    = CH_W'(NUM_CH - 1);
  localparam int unsigned       c_num_ch     = NUM_CH;

  logic [1:0]        state;
  logic [CH_W-1:0]   ch_cnt;
  logic [CH_W-1:0]   sample_ch;
  logic [CH_W-1:0]   next_ch;
  logic [ADDR_W:0]   limit;
  logic [ADDR_W:0]   limit_in;
  logic [ADDR_W:0]   wr_next;
  logic              ch_sel_ok;
  logic              hit;

  // Channel of the current sample, the following channel, and the capture decision.
  always_comb begin
    sample_ch = din_sof ? '0 : ch_cnt;
    next_ch   = (sample_ch == c_last_ch) ? '0 : sample_ch + CH_W'(1);
    ch_sel_ok = (32'(ch_sel) < c_num_ch);
    hit       = din_valid && ch_sel_ok && (sample_ch == ch_sel);
    limit_in  = ((num_samples == '0) || (num_samples > c_depth)) ? c_depth : num_samples;
    wr_next   = wr_count + (ADDR_W+1)'(1);
  end

  // Channel counter tracks position in the frame in every state; sof resyncs it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_cnt <= '0;
    end else if (din_valid) begin
      ch_cnt <= next_ch;
    end
  end

  // Capture FSM and registered BRAM port A drive (one-cycle latency per hit).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= c_st_idle;
      port_a.bram_we      <= 1'b0;
      port_a.bram_en_a    <= 1'b0;
      port_a.bram_addr    <= '0;
      port_a.bram_wr_data <= '0;
      wr_count            <= '0;
      done                <= 1'b0;
      limit               <= c_depth;
    end else begin
      port_a.bram_we   <= 1'b0;
      port_a.bram_en_a <= 1'b0;
      if (abort) begin
        // Abort beats arm/trig and suppresses any write for this cycle's hit.
        state <= c_st_idle;
      end else begin
        case (state)
          c_st_idle, c_st_done: begin
            if (arm) begin
              state    <= c_st_armed;
              wr_count <= '0;
              done     <= 1'b0;
              limit    <= limit_in;
            end
          end
          c_st_armed: begin
            if (arm) begin
              wr_count <= '0;
              limit    <= limit_in;
            end else if (trig) begin
              // The sample arriving alongside trig is deliberately not captured.
              state <= c_st_capture;
            end
          end
          c_st_capture: begin
            if (hit) begin
              port_a.bram_we      <= 1'b1;
              port_a.bram_en_a    <= 1'b1;
              port_a.bram_addr    <= wr_count[ADDR_W-1:0];
              port_a.bram_wr_data <= din_data;
              wr_count            <= wr_next;
              if (wr_next == limit) begin
                state <= c_st_done;
                done  <= 1'b1;
              end
            end
          end
          default: state <= c_st_idle;
        endcase
      end
    end
  end

  assign busy = (state == c_st_armed) || (state == c_st_capture);

endmodule
`default_nettype wire

// File: tb/tb_pix_capture_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pix_capture_writer
// Description : Directed bench for pix_capture_writer. Instance a uses 256
//               channels per frame, instance b uses a single channel so every
//               valid sample is a hit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pix_capture_writer;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int CH_W   = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic              a_valid, a_sof, a_arm, a_abort, a_trig, a_busy, a_done;
  logic [DATA_W-1:0] a_data;
  logic [CH_W-1:0]   a_ch_sel;
  logic [ADDR_W:0]   a_num, a_wr_count;

  logic              b_valid, b_sof, b_arm, b_abort, b_trig, b_busy, b_done;
  logic [DATA_W-1:0] b_data;
  logic [CH_W-1:0]   b_ch_sel;
  logic [ADDR_W:0]   b_num, b_wr_count;

  pix_capture_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_a ();
  pix_capture_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_b ();

  pix_capture_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CH_W(CH_W), .NUM_CH(256)) dut_a (
    .clk(clk), .rst_n(rst_n), .din_valid(a_valid), .din_sof(a_sof), .din_data(a_data),
    .ch_sel(a_ch_sel), .num_samples(a_num), .arm(a_arm), .abort(a_abort), .trig(a_trig),
    .port_a(bus_a), .busy(a_busy), .done(a_done), .wr_count(a_wr_count)
  );

  pix_capture_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CH_W(CH_W), .NUM_CH(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .din_valid(b_valid), .din_sof(b_sof), .din_data(b_data),
    .ch_sel(b_ch_sel), .num_samples(b_num), .arm(b_arm), .abort(b_abort), .trig(b_trig),
    .port_a(bus_b), .busy(b_busy), .done(b_done), .wr_count(b_wr_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int unsigned cyc = 0;

  logic [31:0] a_wa[$], a_wd[$];
  logic [31:0] b_wa[$], b_wd[$];
  int unsigned b_wc[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitors: log every port A write pulse, and enable must track write enable.
  always @(negedge clk) begin
    if (bus_a.bram_we || bus_a.bram_en_a) check("a_en_tracks_we", bus_a.bram_en_a, bus_a.bram_we);
    if (bus_a.bram_we) begin
      a_wa.push_back(32'(bus_a.bram_addr));
      a_wd.push_back(bus_a.bram_wr_data);
    end
    if (bus_b.bram_we || bus_b.bram_en_a) check("b_en_tracks_we", bus_b.bram_en_a, bus_b.bram_we);
    if (bus_b.bram_we) begin
      b_wa.push_back(32'(bus_b.bram_addr));
      b_wd.push_back(bus_b.bram_wr_data);
      b_wc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_samp(input logic sof, input logic [31:0] d);
    a_valid = 1'b1; a_sof = sof; a_data = d;
    tick();
    a_valid = 1'b0; a_sof = 1'b0;
  endtask

  task automatic a_frame(input int f, input int n);
    for (int ch = 0; ch < n; ch++) a_samp(ch == 0, {16'(f), 16'(ch)});
  endtask

  task automatic a_arm_trig();
    a_arm = 1'b1;  tick(); a_arm = 1'b0;
    a_trig = 1'b1; tick(); a_trig = 1'b0;
  endtask

  task automatic b_samp(input logic [31:0] d);
    b_valid = 1'b1; b_data = d;
    tick();
    b_valid = 1'b0;
  endtask

  task automatic b_arm_trig();
    b_arm = 1'b1;  tick(); b_arm = 1'b0;
    b_trig = 1'b1; tick(); b_trig = 1'b0;
  endtask

  task automatic check_a_zero(input string pfx);
    check({pfx, "_we"},    bus_a.bram_we, 1'b0);
    check({pfx, "_en"},    bus_a.bram_en_a, 1'b0);
    check({pfx, "_addr"},  bus_a.bram_addr, '0);
    check({pfx, "_data"},  bus_a.bram_wr_data, '0);
    check({pfx, "_busy"},  a_busy, 1'b0);
    check({pfx, "_done"},  a_done, 1'b0);
    check({pfx, "_count"}, a_wr_count, '0);
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int gaps;
    rst_n = 1'b0;
    {a_valid, a_sof, a_arm, a_abort, a_trig} = '0;
    {b_valid, b_sof, b_arm, b_abort, b_trig} = '0;
    a_data = '0; a_ch_sel = '0; a_num = '0;
    b_data = '0; b_ch_sel = '0; b_num = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_a_zero("rst");
    check("rst_b_busy", b_busy, 1'b0);
    check("rst_b_count", b_wr_count, '0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // ch 5 of 256, four samples, ten frames after trig
    a_ch_sel = 8'd5; a_num = 11'd4; base = a_wa.size();
    a_arm = 1'b1; tick(); a_arm = 1'b0;
    check("t2_busy_armed", a_busy, 1'b1);
    a_trig = 1'b1; tick(); a_trig = 1'b0;
    for (int f = 1; f <= 10; f++) a_frame(f, 256);
    tick();
    check("t2_nwr", a_wa.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      if (base + i < a_wa.size()) begin
        check($sformatf("t2_addr%0d", i), a_wa[base+i], 32'(i));
        check($sformatf("t2_data%0d", i), a_wd[base+i], {16'(i + 1), 16'd5});
      end
    end
    check("t2_done", a_done, 1'b1);
    check("t2_count", a_wr_count, 11'd4);
    check("t2_busy", a_busy, 1'b0);

    // sof after 100 samples resyncs the channel counter
    a_num = 11'd1; base = a_wa.size();
    for (int i = 0; i < 100; i++) a_samp(i == 0, {16'd20, 16'(i)});
    a_arm_trig();
    for (int i = 0; i < 10; i++) a_samp(i == 0, {16'd30, 16'(i)});
    tick();
    check("t4_nwr", a_wa.size() - base, 1);
    if (a_wa.size() > base) begin
      check("t4_data", a_wd[base], {16'd30, 16'd5});
      check("t4_addr", a_wa[base], 32'd0);
    end
    check("t4_done", a_done, 1'b1);
    check("t4_count", a_wr_count, 11'd1);

    // asynchronous reset in the middle of a capture
    a_num = 11'd10; base = a_wa.size();
    a_arm_trig();
    for (int f = 1; f <= 3; f++) a_frame(f, 256);
    for (int ch = 0; ch < 6; ch++) a_samp(ch == 0, {16'd4, 16'(ch)});
    check("t1_we_pending", bus_a.bram_we, 1'b1);
    #5;
    rst_n = 1'b0;
    #1;
    check_a_zero("t1_async");
    @(negedge clk) rst_n = 1'b1;
    tick();
    a_trig = 1'b1;
    a_frame(5, 256);
    a_trig = 1'b0;
    tick();
    check("t1_nwr", a_wa.size() - base, 4);
    if (a_wa.size() >= base + 4) check("t1_last_data", a_wd[base+3], {16'd4, 16'd5});
    check("t1_busy", a_busy, 1'b0);

    // single channel, num_samples=0 means full depth at one write per clock
    b_ch_sel = 8'd0; b_num = 11'd0; base = b_wa.size();
    b_arm_trig();
    for (int i = 0; i < 1030; i++) b_samp(32'(i));
    tick();
    check("t3_nwr", b_wa.size() - base, 1024);
    if (b_wa.size() >= base + 1024) begin
      check("t3_first_addr", b_wa[base], 32'd0);
      check("t3_first_data", b_wd[base], 32'd0);
      check("t3_last_addr", b_wa[base+1023], 32'd1023);
      check("t3_last_data", b_wd[base+1023], 32'd1023);
    end
    gaps = 0;
    for (int i = base + 1; i < b_wc.size(); i++) if (b_wc[i] != b_wc[i-1] + 1) gaps++;
    check("t3_gaps", gaps, 0);
    check("t3_done", b_done, 1'b1);
    check("t3_count", b_wr_count, 11'd1024);

    // abort coincident with the third hit
    b_num = 11'd8; base = b_wa.size();
    b_arm_trig();
    b_samp(32'd100);
    b_samp(32'd101);
    b_abort = 1'b1; b_samp(32'd102); b_abort = 1'b0;
    tick();
    check("t5_nwr", b_wa.size() - base, 2);
    check("t5_count", b_wr_count, 11'd2);
    check("t5_done", b_done, 1'b0);
    check("t5_busy", b_busy, 1'b0);
    b_trig = 1'b1; b_samp(32'd103); b_samp(32'd104); b_trig = 1'b0;
    b_samp(32'd105);
    tick();
    check("t5_nwr_after", b_wa.size() - base, 2);

    // arm+trig together in IDLE, then arm during CAPTURE
    b_num = 11'd5; base = b_wa.size();
    b_arm = 1'b1; b_trig = 1'b1; b_samp(32'd200); b_arm = 1'b0;
    check("t6_busy", b_busy, 1'b1);
    b_samp(32'd201); b_trig = 1'b0;
    check("t6_nwr0", b_wa.size() - base, 0);
    b_samp(32'd202);
    b_samp(32'd203);
    b_arm = 1'b1; b_samp(32'd204); b_arm = 1'b0;
    for (int i = 205; i <= 208; i++) b_samp(32'(i));
    tick();
    check("t6_nwr", b_wa.size() - base, 5);
    if (b_wa.size() >= base + 5) begin
      check("t6_first_data", b_wd[base], 32'd202);
      check("t6_last_data", b_wd[base+4], 32'd206);
      check("t6_last_addr", b_wa[base+4], 32'd4);
    end
    check("t6_count", b_wr_count, 11'd5);
    check("t6_done", b_done, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
